// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the HI/LO multiply/divide controller.
//   i32 / i64   : plain 32- and 64-bit word types
//   muldiv_op_t : 4-bit request opcode driven by the execute stage
//   op_is_signed: true for the two's-complement flavours of each operation
package muldiv_ctrl_pkg;

  typedef logic [31:0] i32;
  typedef logic [63:0] i64;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_MULT  = 4'd1,
    OP_MULTU = 4'd2,
    OP_DIV   = 4'd3,
    OP_DIVU  = 4'd4,
    OP_MTHI  = 4'd5,
    OP_MTLO  = 4'd6,
    OP_MADD  = 4'd7,
    OP_MADDU = 4'd8,
    OP_MSUB  = 4'd9,
    OP_MSUBU = 4'd10
  } muldiv_op_t;

  function automatic logic op_is_signed(muldiv_op_t op);
    return op inside {OP_MULT, OP_DIV, OP_MADD, OP_MSUB};
  endfunction

endpackage

// File: rtl/muldiv_ctrl_hilo_regs.sv
// Architectural HI/LO register pair with independent write enables.
//   clk, resetn     : clock, asynchronous active-low reset (clears HI and LO)
//   wr_hi, wr_lo    : load hi_d into HI / lo_d into LO at the next edge
//   hi_d, lo_d      : next values
//   hi, lo          : current register values
module muldiv_ctrl_hilo_regs
  import muldiv_ctrl_pkg::*;
(
  input  logic clk,
  input  logic resetn,
  input  logic wr_hi,
  input  logic wr_lo,
  input  i32   hi_d,
  input  i32   lo_d,
  output i32   hi,
  output i32   lo
);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hi <= '0;
      lo <= '0;
    end else begin
      if (wr_hi) hi <= hi_d;
      if (wr_lo) lo <= lo_d;
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Sequencing controller for the HI/LO unit. Accepts one request at a time,
// drives the external multicycle multiplier/divider through valid/done
// handshakes, owns HI/LO, reports busy and aborts in-flight work on flush.
//   req_valid/req_ready/req_op/req_a/req_b : request from execute stage
//   flush                                  : cancel in-flight op, block accept
//   busy, hi, lo                           : status and architectural HI/LO
//   mul_valid/mul_sig/mul_a/mul_b/mul_done/mul_c       : multiplier handshake
//   div_valid/div_sig/div_a/div_b/div_done/div_q/div_r : divider handshake
// Build option: define MULDIV_MADD_EN to enable MADD/MADDU/MSUB/MSUBU, which
// add an ACC state accumulating the latched product into {HI,LO}. Without it
// those opcodes are accepted as NOPs.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       resetn,
  input  logic       req_valid,
  output logic       req_ready,
  input  muldiv_op_t req_op,
  input  i32         req_a,
  input  i32         req_b,
  input  logic       flush,
  output logic       busy,
  output i32         hi,
  output i32         lo,
  output logic       mul_valid,
  output logic       mul_sig,
  output i32         mul_a,
  output i32         mul_b,
  input  logic       mul_done,
  input  i64         mul_c,
  output logic       div_valid,
  output logic       div_sig,
  output i32         div_a,
  output i32         div_b,
  input  logic       div_done,
  input  i32         div_q,
  input  i32         div_r
);

`ifdef MULDIV_MADD_EN
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_ACC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;
`endif

  state_t state, state_nxt;
  i32     op_a, op_b;
  logic   op_sig;
  logic   accept;
  logic   wr_hi, wr_lo;
  i32     hi_d, lo_d;

`ifdef MULDIV_MADD_EN
  i64   prod;
  logic op_acc, op_sub;
  i64   acc_res;

  assign acc_res = op_sub ? ({hi, lo} - prod) : ({hi, lo} + prod);
`endif

  assign req_ready = (state == S_IDLE) && !flush;
  assign accept    = req_valid && req_ready;
  assign busy      = (state != S_IDLE);

  // Engine requests come straight from the state, so they are mutually
  // exclusive and drop the cycle after a flush returns us to IDLE.
  assign mul_valid = (state == S_MUL);
  assign div_valid = (state == S_DIV);
  assign mul_sig   = op_sig;
  assign div_sig   = op_sig;
  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign div_a     = op_a;
  assign div_b     = op_b;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= S_IDLE;
      op_a   <= '0;
      op_b   <= '0;
      op_sig <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= req_a;
        op_b   <= req_b;
        op_sig <= op_is_signed(req_op);
      end
    end
  end

`ifdef MULDIV_MADD_EN
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      op_acc <= 1'b0;
      op_sub <= 1'b0;
      prod   <= '0;
    end else begin
      if (accept) begin
        op_acc <= req_op inside {OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU};
        op_sub <= req_op inside {OP_MSUB, OP_MSUBU};
      end
      if (state == S_MUL && mul_done) prod <= mul_c;
    end
  end
`endif

  always_comb begin
    state_nxt = state;
    wr_hi     = 1'b0;
    wr_lo     = 1'b0;
    hi_d      = '0;
    lo_d      = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          case (req_op)
            OP_MTHI: begin
              wr_hi = 1'b1;
              hi_d  = req_a;
            end
            OP_MTLO: begin
              wr_lo = 1'b1;
              lo_d  = req_a;
            end
            OP_MULT, OP_MULTU: state_nxt = S_MUL;
            // Divide by zero is accepted but never reaches the divider.
            OP_DIV, OP_DIVU: if (req_b != '0) state_nxt = S_DIV;
`ifdef MULDIV_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: state_nxt = S_MUL;
`endif
            default: ;
          endcase
        end
      end
      S_MUL: begin
        // Flush wins over a coincident done.
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (mul_done) begin
`ifdef MULDIV_MADD_EN
          if (op_acc) begin
            state_nxt = S_ACC;
          end else begin
            state_nxt    = S_IDLE;
            wr_hi        = 1'b1;
            wr_lo        = 1'b1;
            {hi_d, lo_d} = mul_c;
          end
`else
          state_nxt    = S_IDLE;
          wr_hi        = 1'b1;
          wr_lo        = 1'b1;
          {hi_d, lo_d} = mul_c;
`endif
        end
      end
      S_DIV: begin
        if (flush) begin
          state_nxt = S_IDLE;
        end else if (div_done) begin
          state_nxt = S_IDLE;
          wr_hi     = 1'b1;
          wr_lo     = 1'b1;
          hi_d      = div_r;
          lo_d      = div_q;
        end
      end
`ifdef MULDIV_MADD_EN
      S_ACC: begin
        state_nxt = S_IDLE;
        if (!flush) begin
          wr_hi        = 1'b1;
          wr_lo        = 1'b1;
          {hi_d, lo_d} = acc_res;
        end
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  muldiv_ctrl_hilo_regs u_hilo_regs (
    .clk    (clk),
    .resetn (resetn),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo),
    .hi_d   (hi_d),
    .lo_d   (lo_d),
    .hi     (hi),
    .lo     (lo)
  );

endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Sequencing controller for the CPU's HI/LO unit. It accepts one multiply/divide/move request at a time from the execute stage and drives the external multicycle multiplier and divider through valid/done handshakes. It owns the architectural HI/LO registers, reports busy so the pipeline can stall MFHI/MFLO, and cancels in-flight work on pipeline flush.

## Interface
Parameters:
- none.

Ports:
- clk  in  1  clock
- resetn  in  1  reset, asynchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  request accepted this cycle when req_valid also high
- req_op  in  muldiv_op_t  operation to perform
- req_a, req_b  in  32 each  rs, rt operand values
- flush  in  1  cancel any in-flight operation
- busy  out  1  operation in flight
- hi, lo  out  32 each  architectural HI/LO register values
- mul_valid  out  1  multiplier request
- mul_sig  out  1  signed multiply
- mul_a, mul_b  out  32 each  multiplier operands
- mul_done  in  1  multiplier result valid
- mul_c  in  64  multiplier product
- div_valid  out  1  divider request
- div_sig  out  1  signed divide
- div_a, div_b  out  32 each  dividend, divisor
- div_done  in  1  divider result valid
- div_q, div_r  in  32 each  quotient, remainder

## Operation
- Operations: NOP, MULT, MULTU, DIV, DIVU, MTHI, MTLO; MADD, MADDU, MSUB, MSUBU when enabled.
- States: IDLE, MUL, DIV, ACC (ACC exists only when enabled).
- req_ready = (state==IDLE) && !flush. busy = (state!=IDLE).
- On accept, req_a, req_b and the signed flag latch into op_a, op_b and op_sig. mul_a/mul_b/div_a/div_b and mul_sig/div_sig are driven from these latches, so they are stable for the whole operation.
- MTHI/MTLO: hi or lo is loaded with req_a at the accepting edge; state stays IDLE.
- MULT/MULTU: IDLE→MUL. In MUL, mul_valid=1. On mul_done, {hi,lo} is set to mul_c and the state returns to IDLE.
- DIV/DIVU with req_b≠0: IDLE→DIV. In DIV, div_valid=1. On div_done, lo=div_q, hi=div_r, and the state returns to IDLE.
- DIV/DIVU with req_b==0: accepted, hi/lo unchanged, state stays IDLE, divider never started.
- NOP accepted with no effect.
- Flush in MUL or DIV: state→IDLE next edge with no HI/LO write; mul_valid/div_valid drop. Both engines must tolerate valid dropping mid-operation.
- Flush in the same cycle as done: flush wins, no write.
- Flush in IDLE blocks acceptance that cycle.
- mul_valid and div_valid are never high together.

## Timing
- Reset values: state=IDLE, hi=lo=0, op latches=0. Outputs during reset: busy=0, mul_valid=div_valid=0.
- MTHI/MTLO: accepted at cycle T, new value visible on hi/lo at T+1.
- MULT: accepted at T; mul_valid is high from T+1 until the cycle mul_done=1 (cycle D); hi/lo update at D+1.
- With a two-cycle multiplier, D=T+2, the result is visible at T+3, and req_ready is high again at T+3.
- DIV: same pattern as MULT, with latency set by div_done.
- Back-to-back requests are allowed in the cycle state returns to IDLE.

## Configuration
- Macro MULDIV_MADD_EN.
- When defined: MADD/MADDU/MSUB/MSUBU are legal. The path is IDLE→MUL, then mul_c latches into prod on mul_done, then MUL→ACC. In ACC, {hi,lo} is set to {hi,lo}±prod (64-bit, wrap-around), then ACC→IDLE. This adds one cycle of latency.
- Flush in ACC aborts without a write.
- When undefined: these ops are treated as NOP. The ACC state and prod register are absent.

## Structure
- muldiv_op_t (4-bit enum) goes in the shared defs package; the state enum stays local. Uses the shared i32/i64 typedefs.
- The HI/LO register pair with its write-select logic forms the natural sub-module, hilo_regs. The FSM stays in muldiv_ctrl.
- The multiplier and divider are external, connected via the mul_*/div_* ports.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5, multiplier done 2 cycles after valid → hi=0xFFFFFFFF, lo=0xFFFFFFF1 at T+3; busy high T+1..T+2.
- MULTU 0xFFFFFFFF×0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001; mul_sig=0 throughout.
- DIV a=0xFFFFFFF9 (−7), b=2, divider returns q=0xFFFFFFFD, r=0xFFFFFFFF → lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU by 0 → no div_valid, hi/lo unchanged, req_ready stays high.
- MTHI 0x12345678 then MTLO 0x9ABCDEF0 on consecutive cycles → hi/lo updated on each next cycle.
- MULT, then flush on the cycle of mul_done → hi/lo unchanged, state IDLE next cycle; also reset asserted mid-DIV → hi=lo=0, busy=0 immediately.
- (MULDIV_MADD_EN) hi=0, lo=1, MADD 2,3 → lo=7; MSUBU 1,8 → {hi,lo}=0xFFFFFFFF_FFFFFFFF.
